wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Round-robin Wishbone arbiter: shares one CPU-side slave port (the emitter address-decode mux and the memory/GPIO/timer/FIFO behind it) between N bus masters.
- Grants one master at a time and holds the grant until the slave acks or the master drops cyc.
- Forwards the granted master's request to the slave and routes the ack back to that master only.

Parameters:
- N, 4: number of masters, 2..16.
- TIMEOUT, 255: cycles in BUSY with no ack before a forced release (used only with WB_ARB_TIMEOUT_EN).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_wb_m_adr  in  N*32  master addresses; master k at [32k+31:32k]
- i_wb_m_dat  in  N*32  master write data, same packing
- i_wb_m_sel  in  N*4  master byte selects; master k at [4k+3:4k]
- i_wb_m_we  in  N  master write enables
- i_wb_m_cyc  in  N  master cycle requests
- o_wb_m_rdt  out  32  read data, broadcast to all masters
- o_wb_m_ack  out  N  per-master ack
- o_wb_s_adr  out  32  slave address
- o_wb_s_dat  out  32  slave write data
- o_wb_s_sel  out  4  slave byte select
- o_wb_s_we  out  1  slave write enable
- o_wb_s_cyc  out  1  slave cycle
- i_wb_s_rdt  in  32  slave read data
- i_wb_s_ack  in  1  slave ack
- o_grant  out  N  registered one-hot grant
- o_timeout  out  1  one-cycle pulse on forced release (tied 0 without the macro)

Behaviour:
- Clocking: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset state: grant=0, ptr=0, state=IDLE, timeout counter=0.
  - Outputs in reset: o_wb_s_cyc=0, o_wb_m_ack=0, o_timeout=0, o_grant=0.
  - Asserting reset mid-transaction drops o_wb_s_cyc immediately and forwards no ack.
- IDLE state:
  - Slave outputs adr, dat, sel, we and cyc are all 0.
  - If any i_wb_m_cyc is set, select the first set bit scanning from index ptr upward, wrapping N-1 -> 0.
  - On the next edge: load the one-hot grant, go to BUSY, clear the counter.
  - Latency: a master raising cyc in cycle t, with no contention, sees o_wb_s_cyc=1 in cycle t+1.
- BUSY state with grant index g:
  - Slave outputs adr, dat, sel and we come from master g.
  - o_wb_s_cyc = i_wb_m_cyc[g].
  - o_wb_m_ack[g] = i_wb_s_ack, combinational. All other acks stay 0.
- Release on ack: at the edge where i_wb_s_ack=1, go to IDLE, set ptr=(g+1) mod N, clear grant.
  - At least one IDLE cycle always separates two grants.
- Abort: if i_wb_m_cyc[g]=0 while BUSY with no ack, release on that edge. ptr still advances to g+1 and no ack is issued.
- Simultaneous ack and abort in the same cycle: treat as ack.
- Read data: o_wb_m_rdt = i_wb_s_rdt at all times; masters qualify it with their own ack.
- A requester that arrives during BUSY waits. It is never starved: worst-case wait is N-1 transactions.
- ptr is log2(N) bits and wraps modulo N, including non-power-of-2 N.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- When defined, the counter increments every BUSY cycle without ack. When it reaches TIMEOUT (counter width clog2(TIMEOUT+1)), in that same cycle:
  - o_wb_s_cyc is forced to 0;
  - o_wb_m_ack[g]=1 and o_wb_m_rdt=32'hDEADBEEF;
  - o_timeout=1 for exactly one cycle;
  - the next edge releases to IDLE with ptr=g+1.
- An ack arriving in the same cycle the counter reaches TIMEOUT wins: normal ack, slave rdt, no o_timeout.
- When not defined: no counter, o_timeout=0, and a hung slave holds the grant indefinitely.

Test Plan:
- Single master: master 2 raises cyc with adr=0x40000000, we=1, dat=1 -> o_wb_s_cyc=1 one cycle later with adr=0x40000000; slave acks -> only o_wb_m_ack[2]=1; o_grant returns to 0 on the next edge.
- Contention: masters 0 and 3 raise cyc in the same cycle from reset (ptr=0) -> master 0 is served first, then master 3, with exactly one IDLE cycle between grants.
- Fairness: all 4 masters request continuously, each dropping cyc after its ack and re-raising 1 cycle later -> grant order 0,1,2,3,0,1...; no master waits more than 3 transactions.
- Abort: master 1 is granted and drops cyc before ack -> o_wb_s_cyc=0 that cycle, no ack to any master, ptr=2, master 2 is granted next.
- Reset mid-op: i_rst_n=0 while BUSY -> o_wb_s_cyc, o_grant and o_wb_m_ack go to 0 without waiting for a clock edge; after release, a master 0 request is served first.
- Timeout (macro on, TIMEOUT=8): slave never acks -> exactly 8 BUSY cycles, then o_wb_m_ack[g]=1, o_wb_m_rdt=0xDEADBEEF, one-cycle o_timeout pulse, and the arbiter returns to IDLE.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave port.
// Define WB_ARB_TIMEOUT_EN to force-release a grant held too long.
module wb_rr_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N*32-1:0] i_wb_m_adr,
  input  logic [N*32-1:0] i_wb_m_dat,
  input  logic [N*4-1:0]  i_wb_m_sel,
  input  logic [N-1:0]    i_wb_m_we,
  input  logic [N-1:0]    i_wb_m_cyc,
  output logic [31:0]     o_wb_m_rdt,
  output logic [N-1:0]    o_wb_m_ack,
  output logic [31:0]     o_wb_s_adr,
  output logic [31:0]     o_wb_s_dat,
  output logic [3:0]      o_wb_s_sel,
  output logic            o_wb_s_we,
  output logic            o_wb_s_cyc,
  input  logic [31:0]     i_wb_s_rdt,
  input  logic            i_wb_s_ack,
  output logic [N-1:0]    o_grant,
  output logic            o_timeout
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gidx_q, gidx_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [PW-1:0] pick;
  logic [PW-1:0] ptr_nxt;
  logic          found;
  logic          tmo;

  logic [31:0] adr_a [N];
  logic [31:0] dat_a [N];
  logic [3:0]  sel_a [N];

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign adr_a[k] = i_wb_m_adr[32*k +: 32];
    assign dat_a[k] = i_wb_m_dat[32*k +: 32];
    assign sel_a[k] = i_wb_m_sel[4*k +: 4];
  end

  function automatic int wrap_idx(input int p, input int i);
    int s;
    s = p + i;
    if (s >= N) s = s - N;
    return s;
  endfunction

  // First requester at or after ptr, wrapping N-1 -> 0
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && i_wb_m_cyc[wrap_idx(int'(ptr_q), i)]) begin
        found = 1'b1;
        pick  = PW'(wrap_idx(int'(ptr_q), i));
      end
    end
  end

  assign ptr_nxt = (gidx_q == PW'(N - 1)) ? '0 : gidx_q + 1'b1;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  assign tmo = (state_q == BUSY) && !i_wb_s_ack &&
               (cnt_q == CW'(TIMEOUT));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (state_q != BUSY) begin
      cnt_q <= '0;
    end else if (!i_wb_s_ack && cnt_q != CW'(TIMEOUT)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          gidx_d  = pick;
          grant_d = N'(1) << pick;
        end
      end
      BUSY: begin
        // ack takes precedence, but all three release paths do the same
        if (i_wb_s_ack || !i_wb_m_cyc[gidx_q] || tmo) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = ptr_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    o_wb_s_adr = '0;
    o_wb_s_dat = '0;
    o_wb_s_sel = '0;
    o_wb_s_we  = 1'b0;
    o_wb_s_cyc = 1'b0;
    o_wb_m_ack = '0;
    if (state_q == BUSY) begin
      o_wb_s_adr         = adr_a[gidx_q];
      o_wb_s_dat         = dat_a[gidx_q];
      o_wb_s_sel         = sel_a[gidx_q];
      o_wb_s_we          = i_wb_m_we[gidx_q];
      o_wb_s_cyc         = i_wb_m_cyc[gidx_q] & ~tmo;
      o_wb_m_ack[gidx_q] = i_wb_s_ack | tmo;
    end
  end

  assign o_wb_m_rdt = tmo ? 32'hDEAD_BEEF : i_wb_s_rdt;
  assign o_grant    = grant_q;
  assign o_timeout  = tmo;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter (N=4, TIMEOUT=8).
// Inputs change and outputs are checked between rising edges.
module tb_wb_rr_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*32-1:0] m_adr;
  logic [N*32-1:0] m_dat;
  logic [N*4-1:0]  m_sel;
  logic [N-1:0]    m_we;
  logic [N-1:0]    m_cyc;
  logic [31:0]     m_rdt;
  logic [N-1:0]    m_ack;
  logic [31:0]     s_adr;
  logic [31:0]     s_dat;
  logic [3:0]      s_sel;
  logic            s_we;
  logic            s_cyc;
  logic [31:0]     s_rdt;
  logic            s_ack;
  logic [N-1:0]    grant;
  logic            tmo;

  int tests = 0;
  int fails = 0;

  wb_rr_arbiter #(.N(N), .TIMEOUT(8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_wb_m_adr (m_adr),
    .i_wb_m_dat (m_dat),
    .i_wb_m_sel (m_sel),
    .i_wb_m_we  (m_we),
    .i_wb_m_cyc (m_cyc),
    .o_wb_m_rdt (m_rdt),
    .o_wb_m_ack (m_ack),
    .o_wb_s_adr (s_adr),
    .o_wb_s_dat (s_dat),
    .o_wb_s_sel (s_sel),
    .o_wb_s_we  (s_we),
    .o_wb_s_cyc (s_cyc),
    .i_wb_s_rdt (s_rdt),
    .i_wb_s_ack (s_ack),
    .o_grant    (grant),
    .o_timeout  (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    m_cyc = '0;
    m_we  = '0;
    m_sel = '1;
    s_ack = 1'b0;
    s_rdt = 32'h1234_5678;
    for (int k = 0; k < N; k++) begin
      m_adr[32*k +: 32] = 32'hA000_0000 | k;
      m_dat[32*k +: 32] = 32'h5000_0000 | k;
    end
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cyc", 32'(s_cyc), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ack", 32'(m_ack), 0);
    chk("rst_tmo", 32'(tmo), 0);
    rst_n = 1'b1;

    // single master 2
    @(negedge clk);
    m_adr[64 +: 32] = 32'h4000_0000;
    m_dat[64 +: 32] = 32'h1;
    m_we[2]  = 1'b1;
    m_cyc[2] = 1'b1;
    #1;
    chk("idle_cyc", 32'(s_cyc), 0);
    chk("idle_adr", s_adr, 0);
    @(negedge clk);
    #1;
    chk("m2_grant", 32'(grant), 4);
    chk("m2_cyc", 32'(s_cyc), 1);
    chk("m2_adr", s_adr, 32'h4000_0000);
    chk("m2_dat", s_dat, 1);
    chk("m2_we", 32'(s_we), 1);
    chk("m2_sel", 32'(s_sel), 4'hF);
    chk("m2_noack", 32'(m_ack), 0);
    s_ack = 1'b1;
    #1;
    chk("m2_ack", 32'(m_ack), 4);
    chk("m2_rdt", m_rdt, 32'h1234_5678);
    @(negedge clk);
    s_ack = 1'b0;
    m_cyc = '0;
    m_we  = '0;
    #1;
    chk("m2_rel", 32'(grant), 0);
    chk("m2_ack0", 32'(m_ack), 0);

    // contention 0 and 3 from reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_cyc = 4'b1001;
    @(negedge clk);
    #1;
    chk("ct_g0", 32'(grant), 1);
    chk("ct_adr0", s_adr, 32'hA000_0000);
    s_ack = 1'b1;
    #1;
    chk("ct_ack0", 32'(m_ack), 1);
    @(negedge clk);
    s_ack = 1'b0;
    m_cyc = 4'b1000;
    #1;
    chk("ct_idle", 32'(grant), 0);
    @(negedge clk);
    #1;
    chk("ct_g3", 32'(grant), 8);
    chk("ct_adr3", s_adr, 32'hA000_0003);
    s_ack = 1'b1;
    #1;
    chk("ct_ack3", 32'(m_ack), 8);
    @(negedge clk);
    s_ack = 1'b0;
    m_cyc = '0;
    #1;
    chk("ct_rel", 32'(grant), 0);

    // fairness: all request continuously
    m_cyc = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k > 0) m_cyc[(k + 3) % 4] = 1'b1;
      #1;
      chk("fair_grant", 32'(grant), 32'(1 << (k % 4)));
      s_ack = 1'b1;
      #1;
      chk("fair_ack", 32'(m_ack), 32'(1 << (k % 4)));
      @(negedge clk);
      s_ack = 1'b0;
      m_cyc[k % 4] = 1'b0;
      if (k == 7) m_cyc = '0;
      #1;
      chk("fair_idle", 32'(grant), 0);
    end

    // abort by master 1
    m_cyc = 4'b0110;
    @(negedge clk);
    #1;
    chk("ab_g1", 32'(grant), 2);
    m_cyc[1] = 1'b0;
    #1;
    chk("ab_cyc", 32'(s_cyc), 0);
    chk("ab_noack", 32'(m_ack), 0);
    @(negedge clk);
    #1;
    chk("ab_idle", 32'(grant), 0);
    m_cyc = 4'b1101;
    @(negedge clk);
    #1;
    chk("ab_g2", 32'(grant), 4);
    s_ack = 1'b1;
    @(negedge clk);
    s_ack = 1'b0;
    m_cyc = '0;

    // reset in the middle of a transfer (ptr is 3 here)
    m_cyc = 4'b0010;
    @(negedge clk);
    #1;
    chk("rm_g1", 32'(grant), 2);
    s_ack = 1'b1;
    #1;
    chk("rm_ack", 32'(m_ack), 2);
    rst_n = 1'b0;
    #1;
    chk("rm_cyc", 32'(s_cyc), 0);
    chk("rm_grant", 32'(grant), 0);
    chk("rm_ack0", 32'(m_ack), 0);
    s_ack = 1'b0;
    m_cyc = 4'b1001;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rm_idle", 32'(grant), 0);
    @(negedge clk);
    #1;
    chk("rm_g0", 32'(grant), 1);
    s_ack = 1'b1;
    @(negedge clk);
    s_ack = 1'b0;
    m_cyc = '0;

    // hung slave
    s_rdt = 32'h0BAD_F00D;
    m_cyc = 4'b0001;
    @(negedge clk);
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("to_cyc", 32'(s_cyc), 1);
      chk("to_noack", 32'(m_ack), 0);
      chk("to_notmo", 32'(tmo), 0);
      @(negedge clk);
    end
    #1;
    chk("to_cyc0", 32'(s_cyc), 0);
    chk("to_ack", 32'(m_ack), 1);
    chk("to_rdt", m_rdt, 32'hDEAD_BEEF);
    chk("to_pulse", 32'(tmo), 1);
    @(negedge clk);
    m_cyc = '0;
    #1;
    chk("to_end", 32'(tmo), 0);
    chk("to_rel", 32'(grant), 0);
`else
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("hang_grant", 32'(grant), 1);
      chk("hang_cyc", 32'(s_cyc), 1);
      chk("hang_tmo", 32'(tmo), 0);
      @(negedge clk);
    end
    s_ack = 1'b1;
    #1;
    chk("hang_rdt", m_rdt, 32'h0BAD_F00D);
    @(negedge clk);
    s_ack = 1'b0;
    m_cyc = '0;
    #1;
    chk("hang_rel", 32'(grant), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
